// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache block memory interface and its responder.
// Holds bus widths, the responder FSM encoding and the op encoding.
package mem_if_pkg;

    localparam int BLK_W      = 128;
    localparam int MEM_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Write wins when both request lines are high.
    function automatic op_t req_op(input logic rd, input logic wr);
        op_t op;
        op = OP_RD;
        if (wr) op = OP_WR;
        else if (rd) op = OP_RD;
        return op;
    endfunction

endpackage

// File: rtl/block_mem_responder_if.sv
// Cache-to-memory block interface: level requests, one-cycle completion pulse.
import mem_if_pkg::*;

interface block_mem_responder_if;
    // Handshake: the master raises mem_read or mem_write (level) together with
    // mem_addr/mem_wdata; the slave latches them on the first edge it is idle,
    // later changes are ignored, and mem_ready pulses for exactly one cycle when
    // the block transfer is done (mem_rdata valid from that cycle on for reads).
    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]      mem_wdata;
    logic [BLK_W-1:0]      mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/block_ram_1rw.sv
// Single-port synchronous block array with registered read output.
// Only the output register is reset so it can be swapped for an SRAM macro plus a flop.
module block_ram_1rw #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds until the next read enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/block_mem_responder.sv
// Slow-memory responder for the cache block interface: one 4-word block
// transaction at a time with a fixed request-to-mem_ready latency.
module block_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   proc_reset_n,
    block_mem_responder_if.slave   bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       rd_count,
    output logic [CNT_W-1:0]       wr_count,
    output state_t                 state_dbg
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("block_mem_responder: LATENCY must be in 1..255");
    end

    // BUSY counts down from LATENCY-2 so that RESP lands LATENCY cycles after the request.
    localparam logic [7:0] CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

    state_t              state;
    state_t              next_state;
    logic [7:0]          cnt;
    logic [7:0]          cnt_next;
    logic                take;
    logic                enter_resp;
    op_t                 cur_op;
    op_t                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BLK_W-1:0]    wdata_q;
    logic [ADDR_W-1:0]   ram_addr;
    logic [BLK_W-1:0]    ram_wdata;
    logic                ram_we;
    logic                ram_re;
    logic [BLK_W-1:0]    ram_rdata;
    logic                mem_ready_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.mem_addr[MEM_ADDR_W-1:ADDR_W];

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    take = 1'b1;
                    if (LATENCY == 1) begin
                        next_state = RESP;
                    end else begin
                        next_state = BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == 8'd0) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With LATENCY==1 the array access happens on the accept edge, so the
    // live request fields feed the array while idle and the latched ones after.
    always_comb begin
        enter_resp = (next_state == RESP);
        cur_op     = op_q;
        ram_addr   = addr_q;
        ram_wdata  = wdata_q;
        if (state == IDLE) begin
            cur_op    = req_op(bus.mem_read, bus.mem_write);
            ram_addr  = bus.mem_addr[ADDR_W-1:0];
            ram_wdata = bus.mem_wdata;
        end
        ram_we = enter_resp && (cur_op == OP_WR);
        ram_re = enter_resp && (cur_op == OP_RD);
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_ready_q <= 1'b0;
            busy        <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            mem_ready_q <= enter_resp;
            busy        <= (next_state != IDLE);
            if (take) begin
                op_q    <= cur_op;
                addr_q  <= bus.mem_addr[ADDR_W-1:0];
                wdata_q <= bus.mem_wdata;
            end
            if (enter_resp) begin
                if (cur_op == OP_WR) wr_count <= wr_count + 1'b1;
                else                 rd_count <= rd_count + 1'b1;
            end
        end
    end

    block_ram_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (BLK_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (proc_reset_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.mem_rdata = ram_rdata;
    assign bus.mem_ready = mem_ready_q;
    assign state_dbg     = state;

endmodule

// File: doc/block_mem_responder.md
Name: block_mem_responder

Overview:
Memory-side responder for the cache block interface (mem_read/mem_write, 28-bit block address, 128-bit data, mem_ready). Serves one 4-word block transaction at a time from an internal block array, with a programmable fixed latency. Sits below I-cache/D-cache instances as the synthesizable slow-memory model. Completion is signalled by a one-cycle mem_ready pulse.

Parameters:
ADDR_W, 8, block-index bits used from mem_addr; array depth = 2**ADDR_W blocks of 128 bits.
LATENCY, 4, cycles from request sampled to mem_ready high; legal range 1..255.
CNT_W, 16, width of transaction counters.

Ports:
clk  in  1  clock, rising edge
proc_reset_n  in  1  asynchronous reset, active-low
mem_read  in  1  block read request, level, held until mem_ready
mem_write  in  1  block write request, level, held until mem_ready
mem_addr  in  28  block address; only [ADDR_W-1:0] decoded, upper bits ignored (aliasing)
mem_wdata  in  128  write block, word0 in [31:0]
mem_rdata  out  128  read block, valid in the mem_ready cycle, held until the next read completes
mem_ready  out  1  one-cycle completion pulse
busy  out  1  high in BUSY and RESP
rd_count  out  CNT_W  completed reads, wraps
wr_count  out  CNT_W  completed writes, wraps

Behaviour:
- Reset (async, proc_reset_n=0): state IDLE, mem_ready=0, mem_rdata=0, busy=0, counters=0, latency counter=0. Array contents are not reset.
- All outputs registered; no combinational input-to-output path.
- FSM states: IDLE, BUSY, RESP.
- IDLE with mem_read|mem_write high at an edge:
  - latch op, addr[ADDR_W-1:0], wdata.
  - go to RESP if LATENCY==1; otherwise go to BUSY with cnt=LATENCY-2.
- BUSY: cnt decrements each cycle; at cnt==0, go to RESP.
- Entering RESP:
  - write: array[addr] <= wdata.
  - read: mem_rdata <= array[addr], including a write completed in any earlier transaction.
- RESP lasts exactly one cycle: mem_ready=1, corresponding counter +1, then IDLE.
- Timing: request first high in IDLE cycle T -> mem_ready high in cycle T+LATENCY only.
- Inputs are ignored in BUSY and RESP. Latched values rule:
  - request dropped early: the transaction still completes and pulses mem_ready.
  - address/data changes mid-transaction: no effect.
- Requests seen in the RESP cycle are ignored. The next request is sampled in the following IDLE cycle, so the minimum request-to-request spacing is LATENCY+1 cycles. This matches the cache's WB->ALLC sequence: its write completes, then its read is issued next cycle.
- mem_read and mem_write both high: write takes priority, and only wr_count increments.
- Reset during BUSY: the pending write is discarded (array unchanged), mem_ready is not pulsed, state is IDLE.
- Counters wrap at 2**CNT_W.

Decomposition:
- Shared package mem_if_pkg holds:
  - BLK_W=128, MEM_ADDR_W=28.
  - FSM state encoding constants IDLE/BUSY/RESP.
  - the op encoding OP_RD/OP_WR.
- One natural sub-module: block_ram_1rw, a single-port synchronous 128-bit array (depth 2**ADDR_W, write-enable, registered read). It allows later replacement by an SRAM macro.

Test Plan:
- LATENCY=4: write addr 0x05, data 0x4444_3333_2222_1111 (upper words 0) at cycle 10 -> mem_ready high only in cycle 14; wr_count=1; busy cycles 11..14.
- Read addr 0x05 issued right after that write -> mem_ready 4 cycles later with mem_rdata=0x...4444_3333_2222_1111; rd_count=1; rdata holds after the pulse.
- Cache-like WB then ALLC: write A=0x10, then read B=0x20 with mem_read rising the cycle after the write's mem_ready -> read accepted and data for 0x20 returned. A read returning a new write's data still requires that address to be written first.
- Simultaneous mem_read=mem_write=1 at addr 0x07, wdata=0xAA..AA -> treated as a write; a later read of 0x07 returns 0xAA..AA; rd_count unchanged.
- Request dropped after 1 cycle and addr changed to 0x33 mid-transaction -> exactly one mem_ready pulse, for the original latched addr.
- proc_reset_n asserted during BUSY of a write to 0x09 (prior content 0x1) -> outputs 0 immediately; no mem_ready; a subsequent read of 0x09 returns 0x1.
- LATENCY=1 -> request in cycle T gives mem_ready in T+1; back-to-back reads spaced 2 cycles.
